mem_access_unit: RTL and testbench

MEM-stage memory access engine that sits downstream of the EX/MEM pipeline register. It turns the registered memory controls, address and store data into a single-outstanding Wishbone-classic master transaction, and stalls the upstream pipeline registers while the access is in flight. It also returns aligned, sign-extended load data to the MEM/WB boundary.

---
 rtl/mem_access_unit.sv | 167 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage memory access engine: one outstanding Wishbone-classic transfer per load/store,
// stalls upstream stages while in flight and returns aligned, sign-extended load data.
module mem_access_unit #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    MemRead,
    input  logic                    MemWrite,
    input  logic                    MemSize,
    input  logic [ADDR_WIDTH-1:0]   ALU_result,
    input  logic [DATA_WIDTH-1:0]   rs2_data,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    output logic                    mem_stall,
    output logic [DATA_WIDTH-1:0]   load_data,
    output logic                    load_valid,
    output logic                    bus_err,
    output logic                    misaligned
);

    localparam int unsigned NumLanes   = DATA_WIDTH / 8;
    localparam int unsigned OffW       = $clog2(NumLanes);
    localparam logic [7:0]  TimeoutCnt = 8'(TIMEOUT);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  cyc_q, cyc_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [NumLanes-1:0]   sel_q, sel_d;
    logic                  word_q, word_d;
    logic [OffW-1:0]       off_q, off_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
    logic                  load_valid_q, load_valid_d;
    logic                  bus_err_q, bus_err_d;
    logic                  misaligned_q, misaligned_d;

    logic                  req;
    logic [OffW-1:0]       req_off;
    logic [7:0]            rd_lane;
    logic [DATA_WIDTH-1:0] rd_aligned;

    assign req     = MemRead | MemWrite;
    assign req_off = ALU_result[OffW-1:0];

    // Byte loads pick the addressed lane and sign-extend it.
    assign rd_lane    = wb_dat_i[8*off_q +: 8];
    assign rd_aligned = word_q ? wb_dat_i : {{(DATA_WIDTH-8){rd_lane[7]}}, rd_lane};

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        we_d         = we_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        sel_d        = sel_q;
        word_d       = word_q;
        off_d        = off_q;
        cnt_d        = cnt_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        bus_err_d    = 1'b0;
        misaligned_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (req) begin
                    state_d      = StBusy;
                    cyc_d        = 1'b1;
                    we_d         = MemWrite;
                    adr_d        = {ALU_result[ADDR_WIDTH-1:OffW], OffW'(0)};
                    word_d       = MemSize;
                    off_d        = req_off;
                    sel_d        = MemSize ? '1 : (NumLanes'(1) << req_off);
                    dat_d        = MemSize ? rs2_data : {NumLanes{rs2_data[7:0]}};
                    cnt_d        = 8'd0;
                    misaligned_d = MemSize && (req_off != '0);
                end
            end
            StBusy: begin
                if (wb_ack_i) begin
                    state_d      = StDone;
                    cyc_d        = 1'b0;
                    load_valid_d = !we_q;
                    if (!we_q) begin
                        load_data_d = rd_aligned;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TimeoutCnt) begin
                        state_d      = StDone;
                        cyc_d        = 1'b0;
                        bus_err_d    = 1'b1;
                        load_data_d  = '0;
                        load_valid_d = !we_q;
                    end
                end
            end
            StDone: begin
                // Request still visible here belongs to the instruction just completed.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            word_q       <= 1'b0;
            off_q        <= '0;
            cnt_q        <= 8'd0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            sel_q        <= sel_d;
            word_q       <= word_d;
            off_q        <= off_d;
            cnt_q        <= cnt_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            bus_err_q    <= bus_err_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = cyc_q;
    assign wb_we_o    = we_q;
    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = dat_q;
    assign wb_sel_o   = sel_q;
    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign bus_err    = bus_err_q;
    assign misaligned = misaligned_q;
    assign mem_stall  = ((state_q == StIdle) && req) || (state_q == StBusy);

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus random loads/stores against a
// transaction-level model of the access timing, lane selection and load extension.
module tb_mem_access_unit;

    localparam int TMO = 4;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic        MemSize;
    logic [31:0] ALU_result;
    logic [31:0] rs2_data;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        mem_stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        bus_err;
    logic        misaligned;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_load = 32'h0;

    mem_access_unit #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT   (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .MemSize   (MemSize),
        .ALU_result(ALU_result),
        .rs2_data  (rs2_data),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_o  (wb_sel_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i),
        .mem_stall (mem_stall),
        .load_data (load_data),
        .load_valid(load_valid),
        .bus_err   (bus_err),
        .misaligned(misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One non-memory cycle; a stray ack must have no effect.
    task automatic idle_cycle(input bit stray_ack);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        wb_ack_i = stray_ack;
        wb_dat_i = $urandom;
        @(negedge clk);
        check_val("idle_stall", mem_stall, 0);
        check_val("idle_cyc", wb_cyc_o, 0);
        check_val("idle_stb", wb_stb_o, 0);
        check_val("idle_lvalid", load_valid, 0);
        check_val("idle_berr", bus_err, 0);
        check_val("idle_ldata", load_data, exp_load);
        @(posedge clk);
        #1;
        wb_ack_i = 1'b0;
    endtask

    // Full access from the IDLE cycle through DONE. waits >= TMO means the slave never acks.
    task automatic do_txn(input bit rd, input bit both, input bit word, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input int waits);
        bit          is_write;
        bit          ack_now;
        bit          timed_out;
        int          off;
        logic [31:0] lane;
        logic [31:0] exp_dat;
        logic [3:0]  exp_sel;
        is_write  = !rd || both;
        timed_out = (waits >= TMO);
        off       = int'(addr % 4);
        exp_sel   = word ? 4'hF : 4'(1 << off);
        exp_dat   = word ? wdata : (wdata & 32'hFF) * 32'h0101_0101;

        MemRead    = rd || both;
        MemWrite   = is_write;
        MemSize    = word;
        ALU_result = addr;
        rs2_data   = wdata;
        wb_ack_i   = 1'b0;
        @(negedge clk);
        check_val("req_stall", mem_stall, 1);
        check_val("req_cyc", wb_cyc_o, 0);
        @(posedge clk);
        #1;
        for (int i = 1; i <= TMO; i++) begin
            ack_now  = !timed_out && (i == waits + 1);
            wb_ack_i = ack_now;
            wb_dat_i = ack_now ? rdata : $urandom;
            @(negedge clk);
            check_val("busy_cyc", wb_cyc_o, 1);
            check_val("busy_stb", wb_stb_o, 1);
            check_val("busy_stall", mem_stall, 1);
            check_val("busy_we", wb_we_o, is_write);
            check_val("busy_adr", wb_adr_o, addr & 32'hFFFF_FFFC);
            check_val("busy_sel", wb_sel_o, exp_sel);
            if (is_write) check_val("busy_dat", wb_dat_o, exp_dat);
            check_val("busy_misal", misaligned, (i == 1) && word && (off != 0));
            check_val("busy_lvalid", load_valid, 0);
            @(posedge clk);
            #1;
            wb_ack_i = 1'b0;
            if (ack_now) break;
        end
        if (timed_out) begin
            exp_load = 32'h0;
        end else if (!is_write) begin
            lane     = (rdata >> (8 * off)) & 32'hFF;
            exp_load = word ? rdata : (lane >= 32'h80 ? lane | 32'hFFFF_FF00 : lane);
        end
        // DONE: request still held, must not stall or restart.
        @(negedge clk);
        check_val("done_cyc", wb_cyc_o, 0);
        check_val("done_stall", mem_stall, 0);
        check_val("done_lvalid", load_valid, !is_write);
        check_val("done_berr", bus_err, timed_out);
        check_val("done_misal", misaligned, 0);
        check_val("done_ldata", load_data, exp_load);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        MemSize    = 1'b0;
        ALU_result = 32'h0;
        rs2_data   = 32'h0;
        wb_dat_i   = 32'h0;
        wb_ack_i   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_val("rst_cyc", wb_cyc_o, 0);
        check_val("rst_we", wb_we_o, 0);
        check_val("rst_adr", wb_adr_o, 0);
        check_val("rst_dat", wb_dat_o, 0);
        check_val("rst_sel", wb_sel_o, 0);
        check_val("rst_ldata", load_data, 0);
        check_val("rst_flags", {load_valid, bus_err, misaligned}, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle_cycle(1'b1);

        // Directed cases.
        do_txn(1, 0, 1, 32'h8000_0104, 32'h0, 32'hDEAD_BEEF, 0);
        idle_cycle(1'b0);
        do_txn(1, 0, 0, 32'h8000_0003, 32'h0, 32'h8012_3456, 0);
        do_txn(1, 0, 0, 32'h8000_0001, 32'h0, 32'h8012_3456, 1);
        idle_cycle(1'b0);
        do_txn(0, 0, 0, 32'h8000_0002, 32'h1234_56AB, 32'h0, 0);
        do_txn(0, 0, 1, 32'h8000_0010, 32'hCAFE_F00D, 32'h0, 3);
        do_txn(0, 0, 0, 32'h8000_0011, 32'h0000_0077, 32'h0, 0);
        idle_cycle(1'b1);
        do_txn(1, 0, 1, 32'h8000_0200, 32'h0, 32'h1111_2222, TMO);
        idle_cycle(1'b0);
        do_txn(1, 1, 1, 32'h8000_0300, 32'h5555_AAAA, 32'h0, 2);
        idle_cycle(1'b0);

        // Reset while the strobe is up; a late ack must be ignored.
        MemRead    = 1'b1;
        MemWrite   = 1'b0;
        MemSize    = 1'b1;
        ALU_result = 32'h8000_0400;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_val("mid_stb", wb_stb_o, 1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset   = 1'b1;
        MemRead = 1'b0;
        exp_load = 32'h0;
        @(negedge clk);
        check_val("mid_rst_cyc", wb_cyc_o, 0);
        check_val("mid_rst_stb", wb_stb_o, 0);
        check_val("mid_rst_stall", mem_stall, 0);
        @(posedge clk);
        #1;
        wb_dat_i = 32'hFFFF_FFFF;
        idle_cycle(1'b1);
        idle_cycle(1'b0);
        do_txn(1, 0, 1, 32'h8000_0102, 32'h0, 32'h0BAD_F00D, 1);
        idle_cycle(1'b0);

        // Randomized accesses, some back-to-back.
        for (int n = 0; n < 60; n++) begin
            do_txn($urandom % 2, ($urandom % 8) == 0, $urandom % 2, $urandom, $urandom,
                   $urandom, int'($urandom % 5));
            if ($urandom % 2) idle_cycle($urandom % 2);
        end
        idle_cycle(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
